// File: rtl/ntt_core_param.sv
// In-place radix-2 NTT/INTT mod Q: load N words, N*LOGN compute cycles, first result N*LOGN+1 cycles after the last input; results hold while output_ready is low.
// NTT_INTT_SCALE_EN adds one output register that multiplies inverse results by NINV (latency N*LOGN+2).
module ntt_core_param #(
    parameter int LOGN = 8,
    parameter int DW   = 23,
    parameter int Q    = 8380417,
    parameter int NINV = 8347681
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inverse,
    input  logic            input_valid,
    output logic            input_ready,
    input  logic [DW-1:0]   input_data,
    output logic [LOGN-1:0] tf_addr,
    input  logic [DW-1:0]   tf_data,
    output logic            output_valid,
    input  logic            output_ready,
    output logic [DW-1:0]   output_data,
    output logic            busy
);
    localparam int N = 1 << LOGN;
    localparam logic [DW:0]     QE = (DW+1)'(Q);
    localparam logic [2*DW-1:0] QW = (2*DW)'(Q);
    localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);
    localparam logic [LOGN-1:0] HALF = LOGN'(N / 2);
    localparam logic [LOGN-1:0] ONE  = LOGN'(1);

    // one spare bit so block/stage ends at N compare without wrapping
    typedef logic [LOGN:0] cnt_t;
    localparam cnt_t NC = cnt_t'(N);

    typedef enum logic [2:0] {IDLE, LOAD, BF_RD, BF_WR, OUT} state_t;
    state_t state, state_nxt;

    logic [DW-1:0]   mem [N];
    logic [LOGN-1:0] in_idx, j, start, len, k;
    logic            inv;
    logic [DW-1:0]   a_r, b_r, w_r;
    cnt_t            out_cnt;

    function automatic logic [DW-1:0] add_mod(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= QE) s = s - QE;
        return s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] sub_mod(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (x < y) d = d + QE;
        return d[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] mul_mod(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [2*DW-1:0] p;
        p = {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
        p = p % QW;
        return p[DW-1:0];
    endfunction

    // butterfly datapath; one multiplier shared by both schedules
    logic [DW-1:0]   diff, prod, a_new, b_new;
    logic [LOGN-1:0] j_hi;
    always_comb begin
        diff  = sub_mod(a_r, b_r);
        prod  = mul_mod(w_r, inv ? diff : b_r);
        a_new = inv ? add_mod(a_r, b_r) : add_mod(a_r, prod);
        b_new = inv ? prod : sub_mod(a_r, prod);
        j_hi  = j + len;
    end

    cnt_t blk_end, nxt_start;
    logic last_in_blk, last_blk, last_stage, bf_done;
    always_comb begin
        blk_end     = cnt_t'(start) + cnt_t'(len);
        nxt_start   = blk_end + cnt_t'(len);
        last_in_blk = (cnt_t'(j) + cnt_t'(1)) == blk_end;
        last_blk    = nxt_start == NC;
        last_stage  = inv ? (len == HALF) : (len == ONE);
        bf_done     = last_in_blk && last_blk && last_stage;
    end

    logic in_acc, out_xfer, out_done;
    assign input_ready = (state == IDLE) || (state == LOAD);
    assign busy        = (state != IDLE);
    assign tf_addr     = k;
    assign in_acc      = input_valid && input_ready;
    assign out_xfer    = output_valid && output_ready;
    assign out_done    = out_xfer && (out_cnt == NC - cnt_t'(1));

`ifdef NTT_INTT_SCALE_EN
    localparam logic [DW-1:0] NINV_W = DW'(NINV);
    logic [DW-1:0] out_dat;
    logic          out_vld;
    cnt_t          rd_idx;
    logic          load_out;

    // prefetch the next word on the same edge the current one leaves, so no bubbles
    assign load_out = (state == OUT) && (rd_idx != NC) && (!out_vld || output_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_dat <= '0;
            out_vld <= 1'b0;
            rd_idx  <= '0;
        end else begin
            if (load_out) begin
                out_dat <= inv ? mul_mod(mem[rd_idx[LOGN-1:0]], NINV_W) : mem[rd_idx[LOGN-1:0]];
                out_vld <= 1'b1;
                rd_idx  <= rd_idx + cnt_t'(1);
            end else if (out_xfer) begin
                out_vld <= 1'b0;
            end
            if (out_done) rd_idx <= '0;
        end
    end

    assign output_valid = out_vld;
    assign output_data  = out_dat;
`else
    // NINV only matters when the scaling stage is built in
    logic unused_ninv;
    assign unused_ninv  = ^DW'(NINV);
    assign output_valid = (state == OUT);
    assign output_data  = (state == OUT) ? mem[out_cnt[LOGN-1:0]] : '0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (input_valid) state_nxt = LOAD;
            LOAD:    if (input_valid && in_idx == LAST) state_nxt = BF_RD;
            BF_RD:   state_nxt = BF_WR;
            BF_WR:   state_nxt = bf_done ? OUT : BF_RD;
            OUT:     if (out_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            in_idx  <= '0;
            j       <= '0;
            start   <= '0;
            len     <= '0;
            k       <= '0;
            inv     <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            w_r     <= '0;
            out_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (input_valid) begin
                        inv    <= inverse;
                        in_idx <= in_idx + ONE;
                    end
                end
                LOAD: begin
                    if (input_valid) begin
                        in_idx <= in_idx + ONE;
                        if (in_idx == LAST) begin
                            j     <= '0;
                            start <= '0;
                            len   <= inv ? ONE : HALF;
                            k     <= inv ? LAST : ONE;
                        end
                    end
                end
                BF_RD: begin
                    a_r <= mem[j];
                    b_r <= mem[j_hi];
                    w_r <= inv ? sub_mod('0, tf_data) : tf_data;
                end
                BF_WR: begin
                    if (!last_in_blk) begin
                        j <= j + ONE;
                    end else begin
                        k <= inv ? k - ONE : k + ONE;
                        if (!last_blk) begin
                            start <= nxt_start[LOGN-1:0];
                            j     <= nxt_start[LOGN-1:0];
                        end else begin
                            start <= '0;
                            j     <= '0;
                            len   <= inv ? (len << 1) : (len >> 1);
                        end
                    end
                end
                OUT: begin
                    if (out_xfer) out_cnt <= out_done ? '0 : out_cnt + cnt_t'(1);
                end
                default: ;
            endcase
        end
    end

    // coefficient storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (in_acc) mem[in_idx] <= input_data;
        if (state == BF_WR) begin
            mem[j]    <= a_new;
            mem[j_hi] <= b_new;
        end
    end

endmodule
